iter_div_unit: RTL and testbench
================================

// Module: iter_div_unit
// PURPOSE
//  Parametrised multi-cycle integer divider for the EX stage. Replaces the fixed-latency vendor
//  divider IP pair with one radix-2 restoring engine. Covers signed/unsigned quotient/remainder
//  (div.w, mod.w, div.wu, mod.wu).
//  Adds a valid/ready output handshake, a tag pass-through and a flush for pipeline cancellation.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  TAG_W  8   width of in_tag/out_tag sideband (e.g. {gr_we, dest})
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high reset
//  flush          in   1        cancel in-flight/held op (EX flush)
//  in_valid       in   1        request valid
//  in_ready       out  1        unit can accept a request (state IDLE)
//  in_op          in   2        00 signed quot, 01 signed rem, 10 unsigned quot, 11 unsigned rem
//  in_dividend    in   WIDTH    dividend (rj)
//  in_divisor     in   WIDTH    divisor (rk)
//  in_tag         in   TAG_W    sideband, returned unchanged with result
//  out_valid      out  1        result valid (state DONE)
//  out_ready      in   1        consumer takes result (MEM_allow_in)
//  out_result     out  WIDTH    quotient or remainder per latched op
//  out_quotient   out  WIDTH    final quotient
//  out_remainder  out  WIDTH    final remainder
//  out_tag        out  TAG_W    latched in_tag
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counter=0, all datapath regs=0.
//    Outputs: in_ready=1, out_valid=0, busy=0, out_*=0.
//  - States: IDLE -> BUSY on in_valid&&in_ready (accept edge).
//    BUSY -> DONE on the edge the WIDTH-th iteration completes.
//    DONE -> IDLE on out_valid&&out_ready.
//    DONE holds result stable indefinitely while out_ready=0.
//  - Accept: latch op, tag, sign flags, |dividend|, |divisor|; counter=WIDTH.
//    Abs taken only for signed ops; |MIN| = 2^(WIDTH-1) as unsigned.
//  - Iteration (one per cycle in BUSY): {rem,quo} shifted left 1; trial = rem - divisor (WIDTH+1 bits).
//    If trial non-negative: rem=trial and quo LSB=1. Counter decrements.
//  - Latency: out_valid rises exactly WIDTH cycles after the accept edge, fixed for all operands.
//    No early termination.
//  - in_ready=0 in BUSY and DONE; a new request is not accepted in the same cycle as the result handoff.
//  - Sign fixup, applied on DONE entry into result regs:
//    quotient negated iff signed && sign(dividend)!=sign(divisor); remainder takes dividend's sign.
//  - Divide by zero (divisor==0, any op): out_quotient = all ones; out_remainder = original dividend.
//    Sign fixup is bypassed; latency is unchanged.
//  - Signed overflow MIN / -1: out_quotient = MIN, out_remainder = 0. No exception.
//  - out_result = in_op[0] ? out_remainder : out_quotient (uses latched op).
//  - flush: synchronous; highest priority after reset. Next state IDLE, out_valid=0 next cycle, result discarded.
//    flush && in_valid in the same cycle: the request is NOT accepted.
//  - out_* registered; valid only while out_valid=1 (held at last value otherwise).
//  - out_valid && out_ready && flush in the same cycle: transfer counts, and the unit still returns to IDLE.
// TESTING
//  1. Unsigned 100/7 (op=10, then op=11), WIDTH=32 -> quot 14, rem 2.
//     out_valid exactly 32 cycles after accept.
//  2. Signed -7/2 (op=00, op=01) -> quot 0xFFFFFFFD (-3), rem 0xFFFFFFFF (-1).
//     Also 7/-2 -> -3, rem 1.
//  3. Divide by zero: 0x80000005/0, all four ops -> quot 0xFFFFFFFF, rem 0x80000005, latency 32.
//  4. Overflow 0x80000000 / 0xFFFFFFFF signed -> quot 0x80000000, rem 0.
//  5. Backpressure/flush: hold out_ready=0 for 10 cycles -> result and tag stable, in_ready=0.
//     Flush at BUSY cycle 5 -> out_valid never rises, in_ready=1 next cycle.
//     Reset asserted mid-BUSY -> immediate IDLE.
//  6. WIDTH=8, TAG_W=3: random signed/unsigned pairs vs reference model.
//     Latency 8; back-to-back requests keep tag order.

Source files
------------

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle radix-2 restoring integer divider for the EX stage.
// Handles signed/unsigned quotient and remainder with a fixed latency of WIDTH
// cycles, a valid/ready handshake on both sides, a tag pass-through and a flush.
module iter_div_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sel_rem_q;   // latched in_op[0]: result port shows remainder
  logic             quo_neg_q;   // negate magnitude quotient at the end
  logic             rem_neg_q;   // negate magnitude remainder at the end
  logic             zero_q;      // divisor was zero
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] dvd_orig_q;  // raw dividend, returned as remainder on divide by zero
  logic [WIDTH-1:0] dsr_q;       // |divisor|
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] quo_q;       // dividend bits shifting out, quotient bits shifting in

  logic             accept;
  logic             last_iter;
  logic             is_signed;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  // A flush in the same cycle as a request wins: the request is dropped.
  assign accept    = in_valid && in_ready && !flush;
  assign last_iter = (state == ST_BUSY) && (cnt == CNT_LAST);

  // Operand conditioning: magnitudes for signed ops; |MIN| wraps to 2^(WIDTH-1) unsigned.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    is_signed = ~in_op[1];
    dvd_neg   = is_signed & in_dividend[WIDTH-1];
    dsr_neg   = is_signed & in_divisor[WIDTH-1];
    dvd_abs   = dvd_neg ? -in_dividend : in_dividend;
    dsr_abs   = dsr_neg ? -in_divisor  : in_divisor;
  end

  // One restoring step plus the sign fixup applied when the last step completes.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    // rem_q < divisor, so a set top bit in shifted always beats the divisor;
    // otherwise the borrow shows up in the top bit of the (WIDTH+1)-bit trial.
    trial_ok = shifted[WIDTH] | ~trial[WIDTH];
    rem_nxt  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], trial_ok};
    if (zero_q) begin
      fin_quo = '1;
      fin_rem = dvd_orig_q;
    end else begin
      fin_quo = quo_neg_q ? -quo_nxt : quo_nxt;
      fin_rem = rem_neg_q ? -rem_nxt : rem_nxt;
    end
  end

  // Control FSM: flush overrides everything except reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= ST_IDLE;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept)    state <= ST_BUSY;
        ST_BUSY: if (last_iter) state <= ST_DONE;
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default:                state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: latch operands on accept, then one shift/subtract per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sel_rem_q  <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      tag_q      <= '0;
      dvd_orig_q <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
    end else if (accept) begin
      cnt        <= CNT_INIT;
      sel_rem_q  <= in_op[0];
      quo_neg_q  <= dvd_neg ^ dsr_neg;
      rem_neg_q  <= dvd_neg;
      zero_q     <= (in_divisor == '0);
      tag_q      <= in_tag;
      dvd_orig_q <= in_dividend;
      dsr_q      <= dsr_abs;
      rem_q      <= '0;
      quo_q      <= dvd_abs;
    end else if (state == ST_BUSY && !flush) begin
      cnt        <= cnt - 1'b1;
      rem_q      <= rem_nxt;
      quo_q      <= quo_nxt;
    end
  end

  // Result registers: loaded on DONE entry, held otherwise; a flush discards the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_quotient  <= '0;
      out_remainder <= '0;
      out_result    <= '0;
      out_tag       <= '0;
    end else if (last_iter && !flush) begin
      out_quotient  <= fin_quo;
      out_remainder <= fin_rem;
      out_result    <= sel_rem_q ? fin_rem : fin_quo;
      out_tag       <= tag_q;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb_iter_div_unit: directed WIDTH=32 checks and randomized WIDTH=8 checks of
// iter_div_unit against a plain-arithmetic reference model.
module tb_iter_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32, busy32;
  logic [1:0]  in_op32;
  logic [31:0] in_dividend32, in_divisor32, out_result32, out_quotient32, out_remainder32;
  logic [7:0]  in_tag32, out_tag32;

  logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [1:0]  in_op8;
  logic [7:0]  in_dividend8, in_divisor8, out_result8, out_quotient8, out_remainder8;
  logic [2:0]  in_tag8, out_tag8;

  int n_checks = 0;
  int n_fail   = 0;

  iter_div_unit #(.WIDTH(32), .TAG_W(8)) dut32 (
    .clk(clk), .reset(reset), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_op(in_op32), .in_dividend(in_dividend32), .in_divisor(in_divisor32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_quotient(out_quotient32), .out_remainder(out_remainder32), .out_tag(out_tag32),
    .busy(busy32));

  iter_div_unit #(.WIDTH(8), .TAG_W(3)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op8), .in_dividend(in_dividend8), .in_divisor(in_divisor8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
    .out_quotient(out_quotient8), .out_remainder(out_remainder8), .out_tag(out_tag8),
    .busy(busy8));

  // Reference: integer division on longint; SV / and % truncate toward zero.
  function automatic void ref_div(input int w, input logic [1:0] op, input longint a,
                                  input longint b, output longint q, output longint r);
    longint mask, sa, sb;
    mask = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (op[1]) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a[w-1] ? a - (longint'(1) << w) : a;
      sb = b[w-1] ? b - (longint'(1) << w) : b;
      q  = (sa / sb) & mask;
      r  = (sa % sb) & mask;
    end
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] tag, output int lat);
    @(negedge clk);
    in_valid32 = 1'b1; in_op32 = op; in_dividend32 = a; in_divisor32 = b; in_tag32 = tag;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff32();
    @(negedge clk); out_ready32 = 1'b1;
    @(posedge clk); #1; out_ready32 = 1'b0;
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] tag, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; in_op8 = op; in_dividend8 = a; in_divisor8 = b; in_tag8 = tag;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready32); end
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid32); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy32); end
    n_checks++;
    if ({out_quotient32, out_remainder32, out_result32, out_tag32} !== 104'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h res=%h tag=%h want all 0",
               out_quotient32, out_remainder32, out_result32, out_tag32);
    end
    n_checks++;
    if ({in_ready8, out_valid8, busy8} !== 3'b100) begin
      n_fail++; $display("FAIL reset_dut8: got rdy/vld/busy=%b want 100", {in_ready8, out_valid8, busy8});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  typedef struct { logic [1:0] op; logic [31:0] a, b, q, r; } vec32_t;
  vec32_t vecs [12];

  task automatic test_directed32();
    int lat;
    logic [7:0]  tag;
    logic [31:0] want_res;
    vecs = '{
      '{2'b10, 32'd100,        32'd7,        32'd14,       32'd2},
      '{2'b11, 32'd100,        32'd7,        32'd14,       32'd2},
      '{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF},
      '{2'b01, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF},
      '{2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1},
      '{2'b01, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1},
      '{2'b00, 32'h8000_0005,  32'd0,        32'hFFFF_FFFF, 32'h8000_0005},
      '{2'b01, 32'h8000_0005,  32'd0,        32'hFFFF_FFFF, 32'h8000_0005},
      '{2'b10, 32'h8000_0005,  32'd0,        32'hFFFF_FFFF, 32'h8000_0005},
      '{2'b11, 32'h8000_0005,  32'd0,        32'hFFFF_FFFF, 32'h8000_0005},
      '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0},
      '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0}
    };
    for (int i = 0; i < 12; i++) begin
      tag = 8'(i * 17 + 3);
      want_res = vecs[i].op[0] ? vecs[i].r : vecs[i].q;
      run32(vecs[i].op, vecs[i].a, vecs[i].b, tag, lat);
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 32", i, lat); end
      n_checks++; if (out_quotient32 !== vecs[i].q) begin n_fail++; $display("FAIL dir%0d_quot: got %h want %h", i, out_quotient32, vecs[i].q); end
      n_checks++; if (out_remainder32 !== vecs[i].r) begin n_fail++; $display("FAIL dir%0d_rem: got %h want %h", i, out_remainder32, vecs[i].r); end
      n_checks++; if (out_result32 !== want_res) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, out_result32, want_res); end
      n_checks++; if (out_tag32 !== tag) begin n_fail++; $display("FAIL dir%0d_tag: got %h want %h", i, out_tag32, tag); end
      handoff32();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run32(2'b00, 32'hFFFF_FF9C, 32'd7, 8'hA5, lat);   // -100 / 7 -> -14
    @(negedge clk);
    in_valid32 = 1'b1; in_op32 = 2'b10; in_dividend32 = 32'd9; in_divisor32 = 32'd3; in_tag32 = 8'h5A;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid32, in_ready32} !== 2'b10 || out_result32 !== 32'hFFFF_FFF2 || out_tag32 !== 8'hA5) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h tag=%h want vld=1 rdy=0 res=fffffff2 tag=a5",
                 k, out_valid32, in_ready32, out_result32, out_tag32);
      end
    end
    @(negedge clk); out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0; in_valid32 = 1'b0;
    n_checks++;
    if ({out_valid32, busy32, in_ready32} !== 3'b001) begin
      n_fail++; $display("FAIL handoff_no_accept: got vld/busy/rdy=%b want 001", {out_valid32, busy32, in_ready32});
    end
  endtask

  task automatic test_flush();
    int  lat;
    logic seen;
    @(negedge clk);
    in_valid32 = 1'b1; in_op32 = 2'b10; in_dividend32 = 32'd1000; in_divisor32 = 32'd3; in_tag32 = 8'h11;
    @(posedge clk); #1; in_valid32 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush32 = 1'b1;
    @(posedge clk); #1; flush32 = 1'b0;
    n_checks++;
    if ({busy32, in_ready32, out_valid32} !== 3'b010) begin
      n_fail++; $display("FAIL flush_busy: got busy/rdy/vld=%b want 010", {busy32, in_ready32, out_valid32});
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: got out_valid=1 want never"); end
    @(negedge clk); in_valid32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1; in_valid32 = 1'b0; flush32 = 1'b0;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: got busy=%b want 0", busy32); end
    run32(2'b11, 32'd1000, 32'd3, 8'h22, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL post_flush_latency: got %0d want 32", lat); end
    n_checks++; if (out_result32 !== 32'd1) begin n_fail++; $display("FAIL post_flush_result: got %h want 1", out_result32); end
    @(negedge clk); out_ready32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1; out_ready32 = 1'b0; flush32 = 1'b0;
    n_checks++;
    if ({out_valid32, in_ready32} !== 2'b01) begin
      n_fail++; $display("FAIL flush_with_handoff: got vld/rdy=%b want 01", {out_valid32, in_ready32});
    end
  endtask

  task automatic test_reset_midbusy();
    @(negedge clk);
    in_valid32 = 1'b1; in_op32 = 2'b10; in_dividend32 = 32'd50; in_divisor32 = 32'd5; in_tag32 = 8'h77;
    @(posedge clk); #1; in_valid32 = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b1;
    #1;
    n_checks++;
    if ({busy32, in_ready32, out_valid32} !== 3'b010) begin
      n_fail++; $display("FAIL midbusy_reset_state: got busy/rdy/vld=%b want 010", {busy32, in_ready32, out_valid32});
    end
    n_checks++;
    if ({out_tag32, out_result32} !== 40'h0) begin
      n_fail++; $display("FAIL midbusy_reset_outputs: got tag=%h res=%h want 0", out_tag32, out_result32);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_random8();
    int lat;
    logic [1:0] op;
    logic [7:0] a, b, want_res;
    logic [2:0] tag;
    longint q, r;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom); a = pick8(); b = pick8(); tag = 3'($urandom);
      ref_div(8, op, longint'(a), longint'(b), q, r);
      want_res = op[0] ? r[7:0] : q[7:0];
      run8(op, a, b, tag, lat);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 8", i, lat); end
      n_checks++;
      if (out_quotient8 !== q[7:0] || out_remainder8 !== r[7:0]) begin
        n_fail++; $display("FAIL rnd%0d_qr op=%b %h/%h: got q=%h r=%h want q=%h r=%h",
                           i, op, a, b, out_quotient8, out_remainder8, q[7:0], r[7:0]);
      end
      n_checks++; if (out_result8 !== want_res) begin n_fail++; $display("FAIL rnd%0d_result: got %h want %h", i, out_result8, want_res); end
      n_checks++; if (out_tag8 !== tag) begin n_fail++; $display("FAIL rnd%0d_tag: got %h want %h", i, out_tag8, tag); end
      @(negedge clk); out_ready8 = 1'b1;
      @(posedge clk); #1; out_ready8 = 1'b0;
    end
  endtask

  typedef struct { logic [2:0] tag; logic [7:0] res; } exp8_t;

  task automatic test_back_to_back();
    exp8_t expq[$];
    exp8_t e;
    int sent = 0;
    int recv = 0;
    longint q, r;
    logic [1:0] op;
    logic [7:0] a, b;
    op = 2'($urandom); a = pick8(); b = pick8();
    for (int cyc = 0; cyc < 800 && recv < 24; cyc++) begin
      @(negedge clk);
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (out_valid8 && out_ready8) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got tag=%h res=%h want none", out_tag8, out_result8);
        end else begin
          e = expq.pop_front();
          if (out_tag8 !== e.tag || out_result8 !== e.res) begin
            n_fail++; $display("FAIL b2b_out%0d: got tag=%h res=%h want tag=%h res=%h",
                               recv, out_tag8, out_result8, e.tag, e.res);
          end
        end
        recv++;
      end
      in_valid8 = (sent < 24);
      in_op8 = op; in_dividend8 = a; in_divisor8 = b; in_tag8 = 3'(sent);
      if (in_valid8 && in_ready8) begin
        ref_div(8, op, longint'(a), longint'(b), q, r);
        e.tag = 3'(sent);
        e.res = op[0] ? r[7:0] : q[7:0];
        expq.push_back(e);
        sent++;
        op = 2'($urandom); a = pick8(); b = pick8();
      end
    end
    @(negedge clk); in_valid8 = 1'b0; out_ready8 = 1'b0;
    n_checks++; if (recv !== 24) begin n_fail++; $display("FAIL b2b_count: got %0d want 24", recv); end
  endtask

  initial begin
    reset = 1'b1;
    flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b0; in_op32 = '0;
    in_dividend32 = '0; in_divisor32 = '0; in_tag32 = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_op8 = '0;
    in_dividend8 = '0; in_divisor8 = '0; in_tag8 = '0;
    test_reset();
    test_directed32();
    test_backpressure();
    test_flush();
    test_reset_midbusy();
    test_random8();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
